cic3_conv_ctrl: RTL and testbench

//  Conversion sequencer for the 3rd-order CIC decimator. Runs one conversion per start request:
//  - enables the modulator and clears the CIC state;
//  - generates the decimation strobe at a selectable ratio;
//  - discards the CIC settling outputs, then captures a programmed number of results;
//  - hands results to the readout side over a valid/ready interface.

---
 rtl/cic3_ctrl_pkg.sv | 25 ++
 rtl/cic3_ctrl_fifo.sv | 64 ++++++
 rtl/cic3_conv_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cic3_conv_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic3_ctrl_pkg.sv
// Shared types and helpers for the CIC3 conversion sequencer.
package cic3_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        ACQUIRE,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam int SETTLE_SAMPLES = 3;

    // Terminal count of the decimation counter (ratio - 1).
    function automatic logic [7:0] dec_ratio(input logic [1:0] sel);
        case (sel)
            2'b00:   return 8'd31;
            2'b01:   return 8'd63;
            2'b10:   return 8'd127;
            default: return 8'd255;
        endcase
    endfunction

endpackage

// File: rtl/cic3_ctrl_fifo.sv
// Synchronous result buffer with flush; DEPTH=1 acts as a single holding register.
module cic3_ctrl_fifo
    import cic3_ctrl_pkg::*;
#(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1))
            return '0;
        return p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cic3_conv_ctrl.sv
// Conversion sequencer for the 3rd-order CIC decimator.
// Define CIC3_CTRL_FIFO_EN for a FIFO_DEPTH-entry result FIFO; otherwise a single holding register.
module cic3_conv_ctrl
    import cic3_ctrl_pkg::*;
#(
    parameter int DATA_W     = 25,
    parameter int NSAMP_W    = 8,
    parameter int CAP_DLY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         dec_sel,
    input  logic [NSAMP_W-1:0] num_samples,
    input  logic [DATA_W-1:0]  cic_data,
    input  logic               out_ready,
    output logic               mod_en,
    output logic               cic_clear,
    output logic               dec_stb,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic [NSAMP_W-1:0] sample_cnt
);

`ifdef CIC3_CTRL_FIFO_EN
    localparam int BUF_DEPTH = FIFO_DEPTH;
`else
    localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic [7:0]         dec_cnt;
    logic [7:0]         dec_term;
    logic [1:0]         settle_cnt;
    logic [NSAMP_W-1:0] tag_cnt;
    logic [CAP_DLY-1:0] tag_pipe;
    logic [CAP_DLY-1:0] tag_low;
    logic [1:0]         dec_sel_q;
    logic [NSAMP_W-1:0] num_q;
    logic [NSAMP_W-1:0] sample_cnt_q;
    logic               overrun_q;
    logic               start_acc;
    logic               abort_act;
    logic               strobe;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign dec_term  = dec_ratio(dec_sel_q);
    assign start_acc = start && !abort && (state == IDLE);
    assign abort_act = abort && (state != IDLE);
    assign strobe    = ((state == SETTLE) || (state == ACQUIRE)) && (dec_cnt == dec_term);
    // Oldest tag reaches the end of the pipe: cic_data now holds that tag's result.
    assign push      = tag_pipe[CAP_DLY-1] && !abort_act;
    assign tag_low   = tag_pipe << 1;
    assign pop       = out_valid && out_ready;

    assign dec_stb    = strobe;
    assign busy       = (state != IDLE);
    assign out_valid  = !empty;
    assign overrun    = overrun_q;
    assign sample_cnt = sample_cnt_q;

    always_comb begin
        state_next = state;
        mod_en     = 1'b0;
        cic_clear  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc)
                    state_next = CLEAR;
            end
            CLEAR: begin
                cic_clear  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                mod_en = 1'b1;
                if (strobe && (settle_cnt == 2'(SETTLE_SAMPLES - 1)))
                    state_next = ACQUIRE;
            end
            ACQUIRE: begin
                mod_en = 1'b1;
                if (strobe && (num_q != '0) && (tag_cnt == num_q - NSAMP_W'(1)))
                    state_next = DRAIN;
            end
            DRAIN: begin
                mod_en = 1'b1;
                if (tag_pipe[CAP_DLY-1] && (tag_low == '0))
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_act)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dec_cnt      <= '0;
            settle_cnt   <= '0;
            tag_cnt      <= '0;
            tag_pipe     <= '0;
            dec_sel_q    <= '0;
            num_q        <= '0;
            sample_cnt_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                dec_sel_q    <= dec_sel;
                num_q        <= num_samples;
                sample_cnt_q <= '0;
                overrun_q    <= 1'b0;
            end
            if (abort_act) begin
                tag_pipe <= '0;
                dec_cnt  <= '0;
            end else begin
                tag_pipe[0] <= strobe && (state == ACQUIRE);
                for (int i = 1; i < CAP_DLY; i++)
                    tag_pipe[i] <= tag_pipe[i-1];
                case (state)
                    CLEAR: begin
                        dec_cnt    <= '0;
                        settle_cnt <= '0;
                        tag_cnt    <= '0;
                    end
                    SETTLE, ACQUIRE: begin
                        dec_cnt <= strobe ? 8'd0 : dec_cnt + 8'd1;
                        if (strobe && (state == SETTLE))
                            settle_cnt <= settle_cnt + 2'd1;
                        if (strobe && (state == ACQUIRE))
                            tag_cnt <= tag_cnt + NSAMP_W'(1);
                    end
                    default: ;
                endcase
            end
            if (push) begin
                sample_cnt_q <= sample_cnt_q + NSAMP_W'(1);
                if (full && !pop)
                    overrun_q <= 1'b1;
            end
        end
    end

    cic3_ctrl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort_act),
        .push  (push),
        .pop   (pop),
        .din   (cic_data),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_cic3_conv_ctrl.sv
// Directed/randomised bench for cic3_conv_ctrl against a schedule-based reference model.
module tb_cic3_conv_ctrl;

    localparam int CAP = 2;
`ifdef CIC3_CTRL_FIFO_EN
    localparam int BD = 4;
`else
    localparam int BD = 1;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  dec_sel;
    logic [7:0]  num_samples;
    logic [24:0] cic_data;
    logic        out_ready;
    logic        mod_en;
    logic        cic_clear;
    logic        dec_stb;
    logic [24:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [7:0]  sample_cnt;

    cic3_conv_ctrl #(
        .DATA_W(25), .NSAMP_W(8), .CAP_DLY(CAP), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dec_sel(dec_sel), .num_samples(num_samples), .cic_data(cic_data),
        .out_ready(out_ready), .mod_en(mod_en), .cic_clear(cic_clear),
        .dec_stb(dec_stb), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .overrun(overrun), .sample_cnt(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          modbad = 0;
    int          ovr_first = -1;
    logic [24:0] hist [0:16383];
    int          stb_q[$];
    int          done_q[$];
    int          clr_q[$];
    int          lowbusy_q[$];
    logic [24:0] pop_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe the current cycle, drive fresh CIC data, advance one clock.
    task automatic cycle();
        if (dec_stb === 1'b1) stb_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
        if (cic_clear === 1'b1) clr_q.push_back(cyc);
        if (busy === 1'b1 && mod_en !== 1'b1) lowbusy_q.push_back(cyc);
        if (busy !== 1'b1 && mod_en !== 1'b0) modbad++;
        if (overrun === 1'b1 && ovr_first < 0) ovr_first = cyc;
        if (out_valid === 1'b1 && out_ready === 1'b1) pop_q.push_back(out_data);
        cic_data = 25'($urandom);
        if (cyc < 16384) hist[cyc] = cic_data;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) cycle();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_start(input logic [1:0] sel, input logic [7:0] n, output int t);
        stb_q.delete(); done_q.delete(); clr_q.delete(); lowbusy_q.delete(); pop_q.delete();
        dec_sel = sel;
        num_samples = n;
        start = 1'b1;
        t = cyc;
        cycle();
        start = 1'b0;
        dec_sel = 2'($urandom);
        num_samples = 8'($urandom);
    endtask

    // Push cycle of the j-th captured result (1-based) for a start at t.
    function automatic int push_cyc(input int t, input int d, input int j);
        return t + 1 + d * (3 + j) + CAP;
    endfunction

    task automatic check_conv(input string tag, input int t, input int d, input int n);
        int dn;
        dn = push_cyc(t, d, n) + 1;
        chk({tag, "_nstb"}, stb_q.size(), 3 + n);
        for (int k = 0; k < 3 + n && k < stb_q.size(); k++)
            chk({tag, "_stb"}, stb_q[k], t + 1 + d * (k + 1));
        chk({tag, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({tag, "_done"}, done_q[0], dn);
        chk({tag, "_nclr"}, clr_q.size(), 1);
        if (clr_q.size() > 0) chk({tag, "_clr"}, clr_q[0], t + 1);
        chk({tag, "_nlow"}, lowbusy_q.size(), 2);
        if (lowbusy_q.size() == 2) begin
            chk({tag, "_low0"}, lowbusy_q[0], t + 1);
            chk({tag, "_low1"}, lowbusy_q[1], dn);
        end
        chk({tag, "_npop"}, pop_q.size(), n);
        for (int j = 0; j < n && j < pop_q.size(); j++)
            chk({tag, "_data"}, 32'(pop_q[j]), 32'(hist[push_cyc(t, d, j + 1)]));
        chk({tag, "_scnt"}, 32'(sample_cnt), 32'(n));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mod"}, 32'(mod_en), 0);
        chk({tag, "_clr"}, 32'(cic_clear), 0);
        chk({tag, "_stb"}, 32'(dec_stb), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_vld"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_scnt"}, 32'(sample_cnt), 0);
    endtask

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; abort = 1'b0; dec_sel = 2'b00;
        num_samples = 8'd0; out_ready = 1'b0; cic_data = '0;
        @(negedge clk);
        repeat (3) cycle();
        chk_zero("rst");
        reset = 1'b0;
        cycle();

        // Ratio 32, four results, free-flowing readout
        out_ready = 1'b1;
        do_start(2'b00, 8'd4, t);
        run_until_idle("t1_idle", 2000);
        check_conv("t1", t, 32, 4);

        // Ratio 256, two results
        do_start(2'b11, 8'd2, t);
        run_until_idle("t2_idle", 3000);
        check_conv("t2", t, 256, 2);

        // Stalled readout: buffer fills, later results dropped
        out_ready = 1'b0;
        do_start(2'b00, 8'd6, t);
        ovr_first = -1;
        run_until_idle("t3_idle", 2000);
        chk("t3_scnt", 32'(sample_cnt), 6);
        chk("t3_ovr", 32'(overrun), 1);
        chk("t3_vld", 32'(out_valid), 1);
        chk("t3_ovr_at", ovr_first, push_cyc(t, 32, BD + 1) + 1);
        chk("t3_ndone", done_q.size(), 1);
        pop_q.delete();
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("t3_npop", pop_q.size(), BD);
        for (int j = 0; j < BD && j < pop_q.size(); j++)
            chk("t3_data", 32'(pop_q[j]), 32'(hist[push_cyc(t, 32, j + 1)]));
        chk("t3_empty", 32'(out_valid), 0);
        chk("t3_sticky", 32'(overrun), 1);

        // Abort in ACQUIRE after two captures, then a fresh conversion
        out_ready = 1'b0;
        do_start(2'b00, 8'd8, t);
        run_to(t + 170);
        chk("t4_pre_vld", 32'(out_valid), 1);
        stb_q.delete(); done_q.delete();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_vld", 32'(out_valid), 0);
        chk("t4_mod", 32'(mod_en), 0);
        chk("t4_ovr", 32'(overrun), (BD < 2) ? 1 : 0);
        chk("t4_scnt", 32'(sample_cnt), 2);
        repeat (300) cycle();
        chk("t4_nstb", stb_q.size(), 0);
        chk("t4_ndone", done_q.size(), 0);
        out_ready = 1'b1;
        do_start(2'b00, 8'd1, t);
        chk("t4b_ovr", 32'(overrun), 0);
        chk("t4b_scnt", 32'(sample_cnt), 0);
        chk("t4b_clr", 32'(cic_clear), 1);
        run_until_idle("t4b_idle", 2000);
        check_conv("t4b", t, 32, 1);

        // Continuous mode past the sample counter wrap; mid-run start ignored
        do_start(2'b00, 8'd0, t);
        run_to(t + 1000);
        start = 1'b1;
        dec_sel = 2'b11;
        num_samples = 8'd5;
        cycle();
        start = 1'b0;
        run_to(push_cyc(t, 32, 255) + 1);
        chk("t5_scnt255", 32'(sample_cnt), 255);
        chk("t5_busy", 32'(busy), 1);
        run_to(push_cyc(t, 32, 256) + 1);
        chk("t5_wrap", 32'(sample_cnt), 0);
        chk("t5_nstb", stb_q.size(), 259);
        if (stb_q.size() > 0) chk("t5_last_stb", stb_q[stb_q.size() - 1], t + 1 + 32 * 259);
        chk("t5_ndone", done_q.size(), 0);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t5_abort", 32'(busy), 0);
        chk("t5_npop", pop_q.size(), 256);
        for (int j = 0; j < 256 && j < pop_q.size(); j++)
            chk("t5_data", 32'(pop_q[j]), 32'(hist[push_cyc(t, 32, j + 1)]));

        // Reset during SETTLE, then start+abort together in IDLE
        out_ready = 1'b0;
        do_start(2'b00, 8'd3, t);
        run_to(t + 20);
        chk("t6_mod", 32'(mod_en), 1);
        reset = 1'b1;
        cycle();
        chk_zero("t6_rst");
        reset = 1'b0;
        clr_q.delete();
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        repeat (5) cycle();
        chk("t6_busy2", 32'(busy), 0);
        chk("t6_nclr", clr_q.size(), 0);

        chk("mod_idle", modbad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
